// File: rtl/vcve2_vlsu_agu_if.sv
// Bus bundle for the vector load/store AGU: VRF-side command and element
// streams plus the OBI data-bus master signals. clk/rst are not part of it.
interface vcve2_vlsu_agu_if #(
    parameter int VL_W = 7
);
    // command from the VRF controller
    logic            start_i;
    logic            we_i;
    logic            strided_i;
    logic [31:0]     base_addr_i;
    logic [31:0]     stride_i;
    logic [2:0]      vsew_i;
    logic [VL_W-1:0] vl_i;
    // status
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    // store element stream
    logic [31:0]     st_data_i;
    logic            st_valid_i;
    logic            st_ready_o;
    // load element stream
    logic [31:0]     ld_data_o;
    logic            ld_valid_o;
    logic [VL_W-1:0] ld_idx_o;
    // OBI data bus
    logic            data_req_o;
    logic            data_gnt_i;
    logic [31:0]     data_addr_o;
    logic            data_we_o;
    logic [3:0]      data_be_o;
    logic [31:0]     data_wdata_o;
    logic            data_rvalid_i;
    logic [31:0]     data_rdata_i;
    logic            data_err_i;

    // AGU side
    modport master (
        input  start_i, we_i, strided_i, base_addr_i, stride_i, vsew_i, vl_i,
        output busy_o, done_o, err_o,
        input  st_data_i, st_valid_i,
        output st_ready_o,
        output ld_data_o, ld_valid_o, ld_idx_o,
        output data_req_o,
        input  data_gnt_i,
        output data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_rvalid_i, data_rdata_i, data_err_i
    );

    // VRF controller / bus side
    modport slave (
        output start_i, we_i, strided_i, base_addr_i, stride_i, vsew_i, vl_i,
        input  busy_o, done_o, err_o,
        output st_data_i, st_valid_i,
        input  st_ready_o,
        input  ld_data_o, ld_valid_o, ld_idx_o,
        input  data_req_o,
        output data_gnt_i,
        input  data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/vcve2_vlsu_agu.sv
// Vector load/store address generator and OBI data-bus master.
// Walks vl elements of width vsew (8/16/32 bit), one bus transaction per
// element, single outstanding transaction, abort on misalignment, invalid
// vsew or bus error.
// Optional feature macro: VCVE2_AGU_STRIDED_EN -- when defined, strided_i and
// stride_i select a signed byte stride; otherwise every access is unit-stride
// and the stride registers/adder input are not built.
module vcve2_vlsu_agu #(
    parameter int VL_W = 7
) (
    input logic              clk_i,
    input logic              rst_i,
    vcve2_vlsu_agu_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // element width encodings
    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;

    logic [2:0]      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [VL_W-1:0] idx_q, idx_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [2:0]      vsew_q, vsew_d;
    logic            we_q, we_d;
    logic            err_q, err_d;

`ifdef VCVE2_AGU_STRIDED_EN
    logic            strided_q, strided_d;
    logic [31:0]     stride_q, stride_d;
`else
    // strided_i/stride_i have no effect in this build
    logic            unused_stride;
    assign unused_stride = ^{bus.strided_i, bus.stride_i};
`endif

    // ------------------------------------------------------------------
    // Element decode: width legality, alignment, address step
    // ------------------------------------------------------------------
    logic        vsew_ok;
    logic        misaligned;
    logic [31:0] unit_step;
    logic [31:0] addr_step;
    logic [2:0]  elem_bytes;
    logic [2:0]  lane_off;

    assign vsew_ok    = (vsew_q == SEW_8) || (vsew_q == SEW_16) || (vsew_q == SEW_32);
    assign misaligned = ((vsew_q == SEW_16) && addr_q[0]) ||
                        ((vsew_q == SEW_32) && (addr_q[1:0] != 2'b00));
    assign unit_step  = 32'd1 << vsew_q;
    assign lane_off   = {1'b0, addr_q[1:0]};

`ifdef VCVE2_AGU_STRIDED_EN
    assign addr_step = strided_q ? stride_q : unit_step;
`else
    assign addr_step = unit_step;
`endif

    // number of bytes an element occupies on the bus
    always_comb begin
        case (vsew_q)
            SEW_8:   elem_bytes = 3'd1;
            SEW_16:  elem_bytes = 3'd2;
            default: elem_bytes = 3'd4;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte lanes: byte enables and replicated write data
    // ------------------------------------------------------------------
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_byte;
            logic       lane_en;

            // lane is enabled when it falls inside [offset, offset+bytes)
            always_comb begin
                if (vsew_q == SEW_32) begin
                    lane_en = 1'b1;
                end else begin
                    lane_en = (3'(gi) >= lane_off) && (3'(gi) < (lane_off + elem_bytes));
                end
            end

            // element replicated so every lane carries the byte it would need
            always_comb begin
                case (vsew_q)
                    SEW_8:   lane_byte = bus.st_data_i[7:0];
                    SEW_16:  lane_byte = bus.st_data_i[8*(gi%2) +: 8];
                    default: lane_byte = bus.st_data_i[8*gi +: 8];
                endcase
            end

            assign be_lanes[gi]          = lane_en;
            assign wdata_lanes[8*gi +: 8] = lane_byte;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load element extraction from the returned word
    // ------------------------------------------------------------------
    logic [31:0] rdata_shifted;
    logic [31:0] ld_elem;

    assign rdata_shifted = bus.data_rdata_i >> {addr_q[1:0], 3'b000};

    // zero-extend the selected element to 32 bits
    always_comb begin
        case (vsew_q)
            SEW_8:   ld_elem = {24'h0, rdata_shifted[7:0]};
            SEW_16:  ld_elem = {16'h0, rdata_shifted[15:0]};
            default: ld_elem = rdata_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-facing handshake terms
    // ------------------------------------------------------------------
    logic in_req;
    logic req;
    logic req_fire;
    logic resp_fire;
    logic last_elem;
    logic ld_fire;

    assign in_req    = (state_q == S_REQ);
    // a store can only be offered once the VRF has presented the element
    assign req       = in_req && (!we_q || bus.st_valid_i);
    assign req_fire  = req && bus.data_gnt_i;
    assign resp_fire = (state_q == S_RESP) && bus.data_rvalid_i;
    assign last_elem = (idx_q == (vl_q - VL_W'(1)));
    assign ld_fire   = resp_fire && !we_q && !bus.data_err_i;

    // ------------------------------------------------------------------
    // Next-state logic for the element walk
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        vl_d      = vl_q;
        vsew_d    = vsew_q;
        we_d      = we_q;
        err_d     = err_q;
`ifdef VCVE2_AGU_STRIDED_EN
        strided_d = strided_q;
        stride_d  = stride_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    addr_d    = bus.base_addr_i;
                    idx_d     = '0;
                    vl_d      = bus.vl_i;
                    vsew_d    = bus.vsew_i;
                    we_d      = bus.we_i;
                    err_d     = 1'b0;
`ifdef VCVE2_AGU_STRIDED_EN
                    strided_d = bus.strided_i;
                    stride_d  = bus.stride_i;
`endif
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (vl_q == '0) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (!vsew_ok || misaligned) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_fire) begin
                    if (bus.data_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + VL_W'(1);
                        addr_d  = addr_q + addr_step;
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and operand registers; reset drops any in-flight response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            vl_q      <= '0;
            vsew_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef VCVE2_AGU_STRIDED_EN
            strided_q <= 1'b0;
            stride_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            vl_q      <= vl_d;
            vsew_q    <= vsew_d;
            we_q      <= we_d;
            err_q     <= err_d;
`ifdef VCVE2_AGU_STRIDED_EN
            strided_q <= strided_d;
            stride_q  <= stride_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields are forced to zero outside the request phase so
    // idle/reset values are clean
    // ------------------------------------------------------------------
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = (state_q == S_DONE);
    assign bus.err_o        = (state_q == S_DONE) && err_q;

    assign bus.data_req_o   = req;
    assign bus.data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.data_we_o    = in_req && we_q;
    assign bus.data_be_o    = in_req ? be_lanes : 4'h0;
    assign bus.data_wdata_o = (in_req && we_q) ? wdata_lanes : 32'h0;

    assign bus.st_ready_o   = req_fire && we_q;

    assign bus.ld_valid_o   = ld_fire;
    assign bus.ld_data_o    = ld_fire ? ld_elem : 32'h0;
    assign bus.ld_idx_o     = ld_fire ? idx_q : '0;

endmodule

// File: tb/tb_vcve2_vlsu_agu.sv
// Directed bench for vcve2_vlsu_agu: a memory/bus responder, a transaction
// level model of the expected accesses, a per-cycle compare process and
// literal expectations for each directed scenario.
module tb_vcve2_vlsu_agu;
    localparam int VL_W = 7;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    vcve2_vlsu_agu_if #(.VL_W(VL_W)) bus ();

    vcve2_vlsu_agu #(.VL_W(VL_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] act[$], input logic [31:0] req[$]);
        chk({name, "_count"}, act.size(), req.size());
        for (int i = 0; i < req.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), (i < act.size()) ? act[i] : 32'hDEAD_BEEF, req[i]);
        end
    endtask

    // backing memory content seen by loads
    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ld;
        int          idx;
        bit          berr;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        rsp_q[$];
    bit          exp_err;
    int          exp_st_n;
    logic [31:0] st_elems[$];

    // every access the operation must make, in order, and its final error flag
    task automatic build_model(input bit we, input bit strided, input logic [31:0] base,
                               input logic [31:0] stride, input logic [2:0] vsew,
                               input int vl, input int err_elem);
        int          size;
        logic [31:0] a, step, mask, d;
        acc_t        e;
        exp_q.delete();
        rsp_q.delete();
        exp_err  = 0;
        exp_st_n = 0;
        size = (vsew == 3'd0) ? 1 : (vsew == 3'd1) ? 2 : 4;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        step = 32'(size);
`ifdef VCVE2_AGU_STRIDED_EN
        if (strided) step = stride;
`else
        if (strided) step = 32'(size);
`endif
        if (vl == 0) return;
        if (vsew > 3'd2) begin
            exp_err = 1;
            return;
        end
        a = base;
        for (int i = 0; i < vl; i++) begin
            if ((a % size) != 0) begin
                exp_err = 1;
                return;
            end
            e.waddr = a & ~32'd3;
            e.be    = 4'(((1 << size) - 1) << (a % 4));
            e.we    = we;
            d       = (i < st_elems.size()) ? (st_elems[i] & mask) : 32'h0;
            e.wdata = d * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1);
            e.ld    = (mem_word(e.waddr) >> (8 * (a % 4))) & mask;
            e.idx   = i;
            e.berr  = (i == err_elem);
            exp_q.push_back(e);
            if (we) exp_st_n++;
            if (e.berr) begin
                exp_err = 1;
                return;
            end
            a = a + step;
        end
    endtask

    // ---------------- responder ----------------
    bit          cfg_we;
    int          cfg_err_elem, gnt_delay, rsp_delay, st_delay;
    int          gnt_wait, gnt_count, rsp_cnt, st_ptr;
    bit          st_adv, pend, pend_err;
    logic [31:0] pend_addr;

    initial begin
        bus.start_i = 0; bus.we_i = 0; bus.strided_i = 0; bus.base_addr_i = 0;
        bus.stride_i = 0; bus.vsew_i = 0; bus.vl_i = 0;
        bus.st_data_i = 0; bus.st_valid_i = 0;
        bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 0; bus.data_err_i = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_err_i = 0;
                bus.st_valid_i = 0; pend = 0; st_adv = 0;
            end else begin
                if (st_adv) begin
                    st_ptr++;
                    st_adv = 0;
                end
                if (pend && rsp_cnt >= rsp_delay) begin
                    bus.data_rvalid_i = 1;
                    bus.data_rdata_i  = mem_word(pend_addr);
                    bus.data_err_i    = pend_err;
                    pend = 0;
                end else begin
                    bus.data_rvalid_i = 0;
                    bus.data_err_i    = 0;
                    if (pend) rsp_cnt++;
                end
                bus.st_data_i = (st_ptr < st_elems.size()) ? st_elems[st_ptr] : 32'h0;
                if (st_delay > 0) begin
                    st_delay--;
                    bus.st_valid_i = 0;
                end else begin
                    bus.st_valid_i = cfg_we && (st_ptr < st_elems.size());
                end
                #1;
                if (bus.data_req_o) begin
                    if (gnt_wait >= gnt_delay) begin
                        bus.data_gnt_i = 1;
                        pend      = 1;
                        rsp_cnt   = 0;
                        pend_addr = bus.data_addr_o;
                        pend_err  = (gnt_count == cfg_err_elem);
                        gnt_count++;
                        gnt_wait  = 0;
                        if (bus.data_we_o) st_adv = 1;
                    end else begin
                        bus.data_gnt_i = 0;
                        gnt_wait++;
                    end
                end else begin
                    bus.data_gnt_i = 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int          cyc = 0, done_count = 0, start_cyc = 0, done_cyc = 0;
    int          req_cycles = 0, st_ready_n = 0;
    bit          busy_exp = 0, last_err = 0;
    logic [31:0] obs_addr[$], obs_be[$], obs_wdata[$], obs_idx[$];
    acc_t        cur;

    always @(negedge clk_i) begin
        bit nb;
        cyc++;
        if (rst_i) begin
            exp_q.delete();
            rsp_q.delete();
            busy_exp = 0;
        end else begin
            chk("busy", bus.busy_o, busy_exp);
            if (bus.data_req_o) begin
                req_cycles++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    chk("req_addr", bus.data_addr_o, exp_q[0].waddr);
                    chk("req_be", bus.data_be_o, exp_q[0].be);
                    chk("req_we", bus.data_we_o, exp_q[0].we);
                    if (exp_q[0].we) chk("req_wdata", bus.data_wdata_o, exp_q[0].wdata);
                    if (bus.data_gnt_i) begin
                        obs_addr.push_back(bus.data_addr_o);
                        obs_be.push_back(32'(bus.data_be_o));
                        obs_wdata.push_back(bus.data_wdata_o);
                        $display("txn bus   we=%0b addr=0x%08h be=0x%h wdata=0x%08h",
                                 bus.data_we_o, bus.data_addr_o, bus.data_be_o, bus.data_wdata_o);
                        rsp_q.push_back(exp_q.pop_front());
                    end
                end
            end
            if (bus.st_ready_o) st_ready_n++;
            if (bus.data_rvalid_i && rsp_q.size() != 0) begin
                cur = rsp_q.pop_front();
                if (!cur.we && !cur.berr) begin
                    chk("ld_valid", bus.ld_valid_o, 1);
                    chk("ld_data", bus.ld_data_o, cur.ld);
                    chk("ld_idx", 32'(bus.ld_idx_o), 32'(cur.idx));
                    obs_idx.push_back(32'(bus.ld_idx_o));
                    $display("txn load  idx=%0d data=0x%08h", bus.ld_idx_o, bus.ld_data_o);
                end else begin
                    chk("ld_valid_suppressed", bus.ld_valid_o, 0);
                end
            end else begin
                chk("ld_valid_idle", bus.ld_valid_o, 0);
            end
            nb = busy_exp;
            if (bus.done_o) begin
                done_count++;
                done_cyc = cyc;
                last_err = bus.err_o;
                chk("done_err", bus.err_o, exp_err);
                chk("done_pending", exp_q.size() + rsp_q.size(), 0);
                chk("st_ready_count", st_ready_n, exp_st_n);
                $display("txn done  err=%0b", bus.err_o);
                nb = 0;
            end
            if (bus.start_i && !busy_exp) begin
                start_cyc = cyc;
                nb = 1;
            end
            busy_exp = nb;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input bit we, input bit strided, input logic [31:0] base,
                            input logic [31:0] stride, input logic [2:0] vsew, input int vl,
                            input int err_elem, input int gdly, input int rdly, input int sdly,
                            input logic [31:0] st[$]);
        @(posedge clk_i);
        #3;
        cfg_we = we; cfg_err_elem = err_elem; gnt_delay = gdly; rsp_delay = rdly;
        st_delay = sdly; gnt_wait = 0; gnt_count = 0; st_ptr = 0; st_adv = 0;
        st_elems = st;
        obs_addr.delete(); obs_be.delete(); obs_wdata.delete(); obs_idx.delete();
        req_cycles = 0; st_ready_n = 0;
        build_model(we, strided, base, stride, vsew, vl, err_elem);
        bus.start_i = 1; bus.we_i = we; bus.strided_i = strided; bus.base_addr_i = base;
        bus.stride_i = stride; bus.vsew_i = vsew; bus.vl_i = VL_W'(vl);
        @(posedge clk_i);
        #3;
        bus.start_i = 0;
    endtask

    task automatic wait_done(input string tag);
        int dc, t;
        dc = done_count;
        t  = 0;
        while (done_count == dc && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        #1;
        if (done_count == dc) chk({tag, "_timeout"}, 1, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
        chk({tag, "_req"}, bus.data_req_o, 0);
        chk({tag, "_addr"}, bus.data_addr_o, 0);
        chk({tag, "_be"}, bus.data_be_o, 0);
        chk({tag, "_we"}, bus.data_we_o, 0);
        chk({tag, "_ldv"}, bus.ld_valid_o, 0);
        chk({tag, "_ldd"}, bus.ld_data_o, 0);
        chk({tag, "_str"}, bus.st_ready_o, 0);
    endtask

    logic [31:0] none[$];

    initial begin
        int t;
        none.delete();
        repeat (3) @(posedge clk_i);
        #3;
        chk_idle_outputs("reset");
        rst_i = 0;
        @(negedge clk_i);
        #1;
        chk_idle_outputs("post_reset");

        // unit-stride byte load
        start_op(0, 0, 32'h100, 0, 3'd0, 4, -1, 0, 0, 0, none);
        wait_done("load8");
        chk_q("load8_addr", obs_addr, '{32'h100, 32'h100, 32'h100, 32'h100});
        chk_q("load8_be", obs_be, '{32'h1, 32'h2, 32'h4, 32'h8});
        chk_q("load8_idx", obs_idx, '{32'd0, 32'd1, 32'd2, 32'd3});
        chk("load8_err", last_err, 0);

        // word store with the element stream arriving late
        start_op(1, 0, 32'h200, 0, 3'd2, 2, -1, 0, 0, 4, '{32'hA, 32'hB});
        wait_done("store32");
        chk_q("store32_addr", obs_addr, '{32'h200, 32'h204});
        chk_q("store32_wdata", obs_wdata, '{32'hA, 32'hB});
        chk_q("store32_be", obs_be, '{32'hF, 32'hF});
        chk("store32_err", last_err, 0);

        // negative stride halfwords
        start_op(0, 1, 32'h40, 32'hFFFF_FFFA, 3'd1, 3, -1, 0, 1, 0, none);
        wait_done("stride16");
`ifdef VCVE2_AGU_STRIDED_EN
        chk_q("stride16_addr", obs_addr, '{32'h40, 32'h38, 32'h34});
        chk_q("stride16_be", obs_be, '{32'h3, 32'hC, 32'h3});
`else
        chk_q("stride16_addr", obs_addr, '{32'h40, 32'h40, 32'h44});
        chk_q("stride16_be", obs_be, '{32'h3, 32'hC, 32'h3});
`endif
        chk("stride16_err", last_err, 0);

        // empty vector: done two cycles after start, no bus traffic
        start_op(0, 0, 32'h80, 0, 3'd2, 0, -1, 0, 0, 0, none);
        wait_done("vl0");
        chk("vl0_latency", done_cyc - start_cyc, 2);
        chk("vl0_reqs", req_cycles, 0);
        chk("vl0_err", last_err, 0);

        // misaligned halfword base
        start_op(0, 0, 32'h101, 0, 3'd1, 2, -1, 0, 0, 0, none);
        wait_done("misalign");
        chk("misalign_err", last_err, 1);
        chk("misalign_reqs", req_cycles, 0);

        // invalid element width
        start_op(1, 0, 32'h300, 0, 3'd3, 2, -1, 0, 0, 0, '{32'h1, 32'h2});
        wait_done("badsew");
        chk("badsew_err", last_err, 1);
        chk("badsew_reqs", req_cycles, 0);

        // slow grant (5 low cycles per element) and bus error on element 1
        start_op(0, 0, 32'h500, 0, 3'd2, 4, 1, 5, 0, 0, none);
        wait_done("gnt_err");
        chk("gnt_err_reqcycles", req_cycles, 12);
        chk_q("gnt_err_addr", obs_addr, '{32'h500, 32'h504});
        chk_q("gnt_err_idx", obs_idx, '{32'd0});
        chk("gnt_err_err", last_err, 1);

        // byte store, unaligned start crossing a word
        start_op(1, 0, 32'h603, 0, 3'd0, 3, -1, 1, 2, 0, '{32'h11, 32'h22, 32'h33});
        wait_done("store8");
        chk_q("store8_addr", obs_addr, '{32'h600, 32'h604, 32'h604});
        chk_q("store8_be", obs_be, '{32'h8, 32'h1, 32'h2});
        chk_q("store8_wdata", obs_wdata, '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333});

        // reset while waiting for a response
        start_op(0, 0, 32'h700, 0, 3'd2, 3, -1, 0, 3, 0, none);
        t = 0;
        while (obs_addr.size() == 0 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (obs_addr.size() == 0) chk("rst_resp_timeout", 1, 0);
        @(posedge clk_i);
        #3;
        chk("rst_resp_busy_before", bus.busy_o, 1);
        rst_i = 1;
        #1;
        chk_idle_outputs("rst_async");
        @(negedge clk_i);
        #1;
        chk_idle_outputs("rst_edge");
        @(posedge clk_i);
        #3;
        rst_i = 0;

        // normal operation afterwards, with address wrap at 2**32
        start_op(0, 0, 32'hFFFF_FFFE, 0, 3'd1, 2, -1, 0, 0, 0, none);
        wait_done("wrap16");
        chk_q("wrap16_addr", obs_addr, '{32'hFFFF_FFFC, 32'h0000_0000});
        chk_q("wrap16_be", obs_be, '{32'hC, 32'h3});
        chk_q("wrap16_idx", obs_idx, '{32'd0, 32'd1});
        chk("wrap16_err", last_err, 0);

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
